// File: rtl/bitstream_byte_packer_pkg.sv
// bitstream_byte_packer_pkg
//   Shared constants and types for the bitstream byte packer: input word
//   layout (5-bit valid-bit count over a 30-bit LSB-first payload), the
//   flush marker, accumulator/count widths and the input-ready threshold.
package bitstream_byte_packer_pkg;

    localparam int WORD_W    = 35;
    localparam int NB_HI     = 34;
    localparam int NB_LO     = 30;
    localparam int PAY_W     = 30;
    localparam int ACC_W     = 64;
    localparam int CNT_W     = 7;
    localparam int RDY_LIMIT = 33;

    localparam logic [4:0] NB_FLUSH = 5'd31;

    typedef struct packed {
        logic [NB_HI-NB_LO:0] nb;   // valid-bit count, 31 = flush
        logic [PAY_W-1:0]     pay;  // payload, LSB first
    } word_t;

    // Round a bit count up to the next byte boundary.
    function automatic logic [CNT_W-1:0] roundup8(input logic [CNT_W-1:0] c);
        return (c + CNT_W'(7)) & ~CNT_W'(7);
    endfunction

endpackage

// File: rtl/bitstream_byte_packer.sv
// bitstream_byte_packer
//   Packs variable-length words from the output FIFO into an LSB-first byte
//   stream with a valid/ready output handshake, plus a zero-pad flush marker
//   and a running count of transferred bytes.
//
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   i_data[34:0]     {n[4:0], payload[29:0]}; n=0 no-op, 1..30 bits, 31 flush
//   i_en / i_rdy     input word valid / packer ready (ready from cnt only)
//   o_data[7:0]      output byte, held stable while o_en & ~o_rdy
//   o_en / o_rdy     output byte valid / downstream ready
//   o_byte_cnt[31:0] bytes transferred since reset, wraps
module bitstream_byte_packer
    import bitstream_byte_packer_pkg::*;
#(
    parameter bit SIMULATION = 1'b0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_en,
    output logic              i_rdy,
    output logic [7:0]        o_data,
    output logic              o_en,
    input  logic              o_rdy,
    output logic [31:0]       o_byte_cnt
);

    logic [ACC_W-1:0] acc_q, acc_d, acc_sh, ins;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sh;
    logic [7:0]       o_data_q, o_data_d;
    logic             o_en_q, o_en_d;
    logic [31:0]      byte_cnt_q, byte_cnt_d;
    logic [PAY_W-1:0] pay_mask;
    logic             emit, accept, xfer;
    word_t            word;

    assign word   = word_t'(i_data);
    assign i_rdy  = (cnt_q <= CNT_W'(RDY_LIMIT));
    assign accept = i_en & i_rdy;
    assign xfer   = o_en_q & o_rdy;
    // Output register can take a new byte when empty or being drained now.
    assign emit   = (~o_en_q | o_rdy) & (cnt_q >= CNT_W'(8));

    always_comb begin
        // Shift out the emitted byte first, so new bits land at cnt-8.
        acc_sh   = emit ? (acc_q >> 8) : acc_q;
        cnt_sh   = emit ? (cnt_q - CNT_W'(8)) : cnt_q;
        pay_mask = ~({PAY_W{1'b1}} << word.nb);
        ins      = ACC_W'(word.pay & pay_mask) << cnt_sh;
        acc_d    = acc_sh;
        cnt_d    = cnt_sh;
        if (accept) begin
            if (word.nb == NB_FLUSH) begin
                // Bits above cnt are already zero, so padding is count-only.
                cnt_d = roundup8(cnt_sh);
            end else if (word.nb != '0) begin
                acc_d = acc_sh | ins;
                cnt_d = cnt_sh + CNT_W'(word.nb);
            end
        end
    end

    always_comb begin
        o_data_d   = o_data_q;
        o_en_d     = o_en_q;
        byte_cnt_d = byte_cnt_q + (xfer ? 32'd1 : 32'd0);
        if (emit) begin
            o_data_d = acc_q[7:0];
            o_en_d   = 1'b1;
        end else if (xfer) begin
            o_en_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            o_data_q   <= '0;
            o_en_q     <= 1'b0;
            byte_cnt_q <= '0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            o_data_q   <= o_data_d;
            o_en_q     <= o_en_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign o_data     = o_data_q;
    assign o_en       = o_en_q;
    assign o_byte_cnt = byte_cnt_q;

    generate
        if (SIMULATION) begin : g_stable_chk
            logic       hold_q;
            logic [7:0] data_q;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    hold_q <= 1'b0;
                    data_q <= '0;
                end else begin
                    hold_q <= o_en_q & ~o_rdy;
                    data_q <= o_data_q;
                end
            end
            // A stalled byte must not change before it is taken.
            always @(posedge clk) begin
                if (rstn && hold_q) begin
                    assert (o_data_q == data_q)
                    else $fatal(1, "o_data changed while stalled");
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_bitstream_byte_packer.sv
// Testbench for bitstream_byte_packer: directed and random stimulus against a
// bit-queue reference model of the packer's observable behaviour.
module tb_bitstream_byte_packer;

    logic        clk;
    logic        rstn;
    logic [34:0] i_data;
    logic        i_en;
    logic        i_rdy;
    logic [7:0]  o_data;
    logic        o_en;
    logic        o_rdy;
    logic [31:0] o_byte_cnt;

    int checks = 0;
    int errors = 0;

    bitstream_byte_packer #(.SIMULATION(1'b1)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_data     (i_data),
        .i_en       (i_en),
        .i_rdy      (i_rdy),
        .o_data     (o_data),
        .o_en       (o_en),
        .o_rdy      (o_rdy),
        .o_byte_cnt (o_byte_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: bits waiting to be packed, plus the output register.
    bit          acc_m[$];
    logic        m_oen;
    logic [7:0]  m_odata;
    logic [31:0] m_bcnt;
    logic [7:0]  out_q[$];
    logic        last_acc, last_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        acc_m.delete();
        m_oen   = 1'b0;
        m_odata = 8'h00;
        m_bcnt  = 32'd0;
    endtask

    // One clock: check outputs at negedge, advance the model, return #1 after posedge.
    task automatic step();
        logic       m_rdy, emit, xfer, acc;
        logic [4:0] n;
        @(negedge clk);
        m_rdy = (acc_m.size() <= 33);
        chk("i_rdy", 32'(i_rdy), 32'(m_rdy));
        chk("o_en", 32'(o_en), 32'(m_oen));
        chk("o_data", 32'(o_data), 32'(m_odata));
        chk("o_byte_cnt", o_byte_cnt, m_bcnt);
        xfer = m_oen && o_rdy;
        emit = (!m_oen || o_rdy) && (acc_m.size() >= 8);
        acc  = i_en && m_rdy;
        if (o_en && o_rdy) out_q.push_back(o_data);
        last_rdy = i_rdy;
        last_acc = acc;
        if (xfer) m_bcnt++;
        if (emit) begin
            for (int b = 0; b < 8; b++) m_odata[b] = acc_m.pop_front();
            m_oen = 1'b1;
        end else if (xfer) begin
            m_oen = 1'b0;
        end
        if (acc) begin
            n = i_data[34:30];
            if (n == 5'd31) begin
                while (acc_m.size() % 8 != 0) acc_m.push_back(1'b0);
            end else begin
                for (int b = 0; b < int'(n); b++) acc_m.push_back(i_data[b]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) step();
    endtask

    task automatic send(input logic [4:0] n, input logic [29:0] p);
        i_data = {n, p};
        i_en   = 1'b1;
        for (int k = 0; k < 200; k++) begin
            step();
            if (last_acc) break;
        end
        chk("send_accepted", 32'(last_acc), 32'd1);
        i_en = 1'b0;
    endtask

    function automatic logic [29:0] bp_word(input int k);
        return 30'h1234567 + 30'(k) * 30'h0F0F0F1;
    endfunction

    initial begin
        bit         exp_bits[$];
        logic [7:0] exp_bytes[$];
        logic [7:0] tmp;
        int         k;
        logic       saw_low;

        rstn   = 1'b0;
        i_en   = 1'b0;
        i_data = '0;
        o_rdy  = 1'b1;
        model_reset();
        #12;
        chk("rst_i_rdy", 32'(i_rdy), 32'd1);
        chk("rst_o_en", 32'(o_en), 32'd0);
        chk("rst_o_data", 32'(o_data), 32'd0);
        chk("rst_byte_cnt", o_byte_cnt, 32'd0);
        #1 rstn = 1'b1;
        idle(4);

        // Two nibbles form one byte.
        out_q.delete();
        send(5'd4, 30'h5);
        send(5'd4, 30'hA);
        idle(4);
        chk("a5_count", 32'(out_q.size()), 32'd1);
        if (out_q.size() >= 1) chk("a5_byte", 32'(out_q[0]), 32'hA5);
        chk("a5_byte_cnt", o_byte_cnt, 32'd1);

        // 30 ones then flush.
        out_q.delete();
        send(5'd30, 30'h3FFFFFFF);
        send(5'd31, 30'h0);
        idle(6);
        chk("ff_count", 32'(out_q.size()), 32'd4);
        if (out_q.size() == 4) begin
            chk("ff_b0", 32'(out_q[0]), 32'hFF);
            chk("ff_b1", 32'(out_q[1]), 32'hFF);
            chk("ff_b2", 32'(out_q[2]), 32'hFF);
            chk("ff_b3", 32'(out_q[3]), 32'h3F);
        end

        // Flush at a byte boundary is a no-op; upper payload bits are masked.
        out_q.delete();
        send(5'd31, 30'h3FFFFFFF);
        idle(4);
        chk("flush0_count", 32'(out_q.size()), 32'd0);
        send(5'd3, 30'h3FFFFFFF);
        send(5'd31, 30'h0);
        idle(4);
        chk("mask_count", 32'(out_q.size()), 32'd1);
        if (out_q.size() >= 1) chk("mask_byte", 32'(out_q[0]), 32'h07);

        // Backpressure: hold o_rdy low while streaming 30-bit words.
        out_q.delete();
        o_rdy   = 1'b0;
        saw_low = 1'b0;
        k       = 0;
        i_en    = 1'b1;
        i_data  = {5'd30, bp_word(0)};
        for (int c = 0; c < 12; c++) begin
            step();
            if (!last_rdy) saw_low = 1'b1;
            if (last_acc) begin
                k++;
                i_data = {5'd30, bp_word(k)};
            end
        end
        chk("bp_saw_rdy_low", 32'(saw_low), 32'd1);
        chk("bp_words_taken", 32'(k), 32'd2);
        o_rdy = 1'b1;
        for (int c = 0; c < 100 && k < 6; c++) begin
            step();
            if (last_acc) begin
                k++;
                i_data = {5'd30, bp_word(k)};
            end
        end
        chk("bp_all_words", 32'(k), 32'd6);
        i_en = 1'b0;
        send(5'd31, 30'h0);
        idle(20);
        for (int w = 0; w < 6; w++) begin
            logic [29:0] wv;
            wv = bp_word(w);
            for (int b = 0; b < 30; b++) exp_bits.push_back(wv[b]);
        end
        while (exp_bits.size() % 8 != 0) exp_bits.push_back(1'b0);
        while (exp_bits.size() != 0) begin
            for (int b = 0; b < 8; b++) tmp[b] = exp_bits.pop_front();
            exp_bytes.push_back(tmp);
        end
        chk("bp_count", 32'(out_q.size()), 32'(exp_bytes.size()));
        for (int b = 0; b < exp_bytes.size() && b < out_q.size(); b++)
            chk("bp_byte", 32'(out_q[b]), 32'(exp_bytes[b]));

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            logic [4:0] n;
            n      = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
            i_data = {n, 30'($urandom)};
            i_en   = 1'($urandom);
            o_rdy  = ($urandom_range(0, 3) != 0);
            step();
        end
        i_en  = 1'b0;
        o_rdy = 1'b1;
        send(5'd31, 30'h0);
        idle(20);
        chk("rand_drained_o_en", 32'(o_en), 32'd0);

        // Reset with a pending byte and 17 partial bits.
        out_q.delete();
        o_rdy = 1'b0;
        send(5'd8, 30'h3FFFFF3C);
        idle(1);
        send(5'd17, 30'h0001ABCD);
        chk("pre_rst_o_en", 32'(o_en), 32'd1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_o_en", 32'(o_en), 32'd0);
        chk("mid_rst_i_rdy", 32'(i_rdy), 32'd1);
        chk("mid_rst_byte_cnt", o_byte_cnt, 32'd0);
        model_reset();
        #1 rstn = 1'b1;
        o_rdy = 1'b1;
        send(5'd4, 30'h3);
        send(5'd4, 30'hC);
        idle(5);
        chk("post_rst_count", 32'(out_q.size()), 32'd1);
        if (out_q.size() >= 1) chk("post_rst_byte", 32'(out_q[0]), 32'hC3);
        chk("post_rst_byte_cnt", o_byte_cnt, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bitstream_byte_packer.md
# bitstream_byte_packer

Drains the 35-bit words produced by the output elastic FIFO and packs them into an LSB-first byte stream for the gzip output port. It sits directly after the FIFO and asserts backpressure through `i_rdy`, which connects to the FIFO's `o_rdy`. It also accepts a flush marker that zero-pads the stream to a byte boundary and keeps a running count of emitted bytes.

## Interface
- `SIMULATION`, default 0: when 1, enables a bench-only check that halts with an error if `o_data` changes while `o_en & ~o_rdy`.
- `clk`, input, 1: clock.
- `rstn`, input, 1: reset; asynchronous, active-low.
- `i_data`, input, 35: `[34:30]` = n (valid-bit count), `[29:0]` = payload bits, LSB first.
- `i_en`, input, 1: input word valid (FIFO `o_en`).
- `i_rdy`, output, 1: packer can accept a word this cycle (to FIFO `o_rdy`).
- `o_data`, output, 8: output byte.
- `o_en`, output, 1: output byte valid.
- `o_rdy`, input, 1: downstream accepts byte.
- `o_byte_cnt`, output, 32: total bytes transferred since reset; wraps modulo 2^32.

## Operation
- State:
  - 64-bit accumulator `acc`, LSB = oldest bit.
  - 7-bit bit count `cnt` (0..63).
  - Output register `o_data`/`o_en`.
- Input transfer when `i_en & i_rdy`. `i_rdy = (cnt <= 33)`, combinational from registered `cnt` only, so it is never a function of `i_en`/`o_rdy`.
- Word decode:
  - n = 0: accepted, no effect.
  - n = 1..30: `i_data[n-1:0]` is appended above the current valid bits. Payload bits `[29:n]` are masked to 0 and ignored.
  - n = 31: flush. `cnt` rounds up to the next multiple of 8 and the pad bits are 0. `cnt` already a multiple of 8 (including 0) is a no-op.
- Byte emit:
  - Condition: `(~o_en | o_rdy)` and `cnt >= 8` at the start of the cycle.
  - Action: `o_data <= acc[7:0]`, `o_en <= 1`, `acc >>= 8`, `cnt -= 8`.
  - If there is no emit and `o_rdy & o_en`, then `o_en <= 0`.
- Simultaneous accept and emit:
  - New bits are inserted at position `cnt-8` (post-shift).
  - `cnt_next = cnt - 8 + n`, or `roundup8(cnt - 8)` for a flush.
- Width rules:
  - Maximum `cnt` after accept is 33+30 = 63, which fits 7 bits and never overflows.
  - Maximum flush result is 40.
  - Accumulator bits at or above `cnt` are always 0.
- `o_byte_cnt` increments on every `o_en & o_rdy`.
- Bits left below a byte boundary are held indefinitely until more input or a flush arrives. No timeout.

## Timing
- Reset values: `i_rdy` = 1 (`cnt` = 0), `o_en` = 0, `o_data` = 0, `o_byte_cnt` = 0, `acc` = 0.
- Reset mid-operation: all partial bits and any pending byte are discarded immediately (asynchronous).
- Latency: word accepted in cycle t that completes a byte → `o_en` = 1 with that byte in cycle t+2.
- Throughput:
  - 1 word/cycle in while `cnt <= 33`.
  - 1 byte/cycle out with `o_rdy` held high.
  - Sustained 30-bit words self-throttle `i_rdy`.
- Output handshake:
  - `o_data` is stable while `o_en & ~o_rdy`.
  - `o_en` only drops after a transfer.
  - A byte may be reloaded in the same cycle as its predecessor transfers, giving back-to-back bytes.
- `o_rdy` low does not block input until `cnt > 33`.

## Structure
- Shared package constants:
  - `WORD_W` = 35
  - `NB_HI` = 34, `NB_LO` = 30
  - `PAY_W` = 30
  - `NB_FLUSH` = 5'd31
  - `ACC_W` = 64
  - `CNT_W` = 7
  - `RDY_LIMIT` = 33
- Single module, no sub-module. The insertion shifter (64-bit barrel left shift by `cnt`) is inline combinational logic.

## Test plan
- Reset → `i_rdy`=1, `o_en`=0, `o_byte_cnt`=0, and they stay so with no input.
- Words {n=4, 0x5}, then {n=4, 0xA} → single byte 0xA5, `o_byte_cnt`=1; with `o_rdy`=1, `o_en` is high for one cycle only.
- {n=30, 0x3FFFFFFF}, then flush → bytes FF, FF, FF, 3F; `cnt` returns to 0.
- Flush with `cnt`=0 → no byte; {n=3, 0x7 with upper payload bits all 1}, then flush → single byte 0x07 (masking verified).
- Backpressure:
  - Stimulus: `o_rdy`=0; stream n=30 words of incrementing pattern.
  - Required: `i_rdy` deasserts after `cnt` exceeds 33; `o_data` is stable throughout; no word is accepted while `i_rdy`=0.
  - Release: `o_rdy`=1 → byte stream matches the reference bit concatenation exactly.
- Assert `rstn` low mid-stream with a pending byte and 17 partial bits → `o_en`=0, `i_rdy`=1, `o_byte_cnt`=0; the next stream is output with no stale bits.
